// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified I/D RAM port arbiter.
package mem_arb_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned LAT_W          = 4;
    localparam int unsigned STARVE_MAX_DEF = 3;

    // Counter width able to hold 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned STARVE_W = cnt_w(STARVE_MAX_DEF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational IF/MEM pick: MEM wins a contest unless the starvation flag forces IF.
module arb_prio_sel (
    input  logic if_req,
    input  logic mem_req,
    input  logic force_if,
    output logic if_sel_c,
    output logic mem_sel_c
);

    always_comb begin
        if_sel_c  = 1'b0;
        mem_sel_c = 1'b0;
        if (if_req && mem_req) begin
            if (force_if) begin
                if_sel_c = 1'b1;
            end else begin
                mem_sel_c = 1'b1;
            end
        end else if (mem_req) begin
            mem_sel_c = 1'b1;
        end else if (if_req) begin
            if_sel_c = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port unified RAM arbiter between IF fetch and MEM load/store, one access in flight.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned RAM_LAT    = 2,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned AW         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_conflict_cnt,
    output logic [31:0]       perf_force_cnt
`endif
);

    localparam int unsigned SW = (cnt_w(STARVE_MAX) > STARVE_W) ? cnt_w(STARVE_MAX) : STARVE_W;
    localparam logic [LAT_W-1:0] LAT_END    = LAT_W'(RAM_LAT);
    localparam logic [SW-1:0]    STARVE_TOP = SW'(STARVE_MAX);

    arb_state_t       state_q, state_d;
    arb_owner_t       owner_q, owner_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             we_q, we_d;
    logic [SW-1:0]    starve_q;
    logic             capture_c;
    logic             force_if_c;
    logic             if_sel_c;
    logic             mem_sel_c;

    assign force_if_c = (starve_q == STARVE_TOP);

    arb_prio_sel u_prio_sel (
        .if_req    (if_req),
        .mem_req   (mem_req),
        .force_if  (force_if_c),
        .if_sel_c  (if_sel_c),
        .mem_sel_c (mem_sel_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= OWN_NONE;
            lat_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
            we_q    <= we_d;
        end
    end

    // Grants are masked while reset is held so the RAM strobe cannot fire during reset.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        we_d      = we_q;
        capture_c = 1'b0;
        if_gnt    = 1'b0;
        mem_gnt   = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (!reset && (if_sel_c || mem_sel_c)) begin
                    state_d = S_WAIT;
                    lat_d   = LAT_W'(1);
                    ram_en  = 1'b1;
                    if (mem_sel_c) begin
                        mem_gnt   = 1'b1;
                        owner_d   = OWN_MEM;
                        we_d      = mem_we;
                        ram_we    = mem_we;
                        ram_addr  = mem_addr;
                        ram_wdata = mem_wdata;
                    end else begin
                        if_gnt   = 1'b1;
                        owner_d  = OWN_IF;
                        we_d     = 1'b0;
                        ram_addr = if_addr;
                    end
                end
            end
            S_WAIT: begin
                if (lat_q == LAT_END) begin
                    state_d   = S_RESP;
                    capture_c = 1'b1;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                lat_d   = '0;
                we_d    = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                lat_d   = '0;
                we_d    = 1'b0;
            end
        endcase
    end

    // Response capture: rvalid flops rise in RESP; a store leaves mem_rdata untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rvalid  <= 1'b0;
            mem_rvalid <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            if_rvalid  <= capture_c && (owner_q == OWN_IF);
            mem_rvalid <= capture_c && (owner_q == OWN_MEM);
            if (capture_c && (owner_q == OWN_IF)) begin
                if_rdata <= ram_rdata;
            end
            if (capture_c && (owner_q == OWN_MEM) && !we_q) begin
                mem_rdata <= ram_rdata;
            end
        end
    end

    // Counts MEM wins over a waiting IF; saturates so the forced IF grant is guaranteed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else if (if_gnt) begin
            starve_q <= '0;
        end else if (mem_gnt && if_req && (starve_q != STARVE_TOP)) begin
            starve_q <= starve_q + SW'(1);
        end
    end

    assign if_stall  = if_req && !if_rvalid;
    assign mem_stall = mem_req && !mem_rvalid;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_conflict_cnt <= '0;
            perf_force_cnt    <= '0;
        end else begin
            if ((state_q == S_IDLE) && if_req && mem_req) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            if (if_gnt && mem_req) begin
                perf_force_cnt <= perf_force_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
